dmem_dump_arbiter: RTL and testbench
====================================

// Module: dmem_dump_arbiter
// PURPOSE
//  Arbitrates the single data-memory port between the pipeline MEM stage and the debug unit.
//  On a debug dump request it stalls the pipeline and waits for the MEM stage to go quiet.
//  It then walks every data-memory word in order, streaming each over a valid/ready link.
//  It sits between the MEM stage address/control path and mem_data.
// PARAMETERS
//  DATA_SIZE  32  data-memory word width
//  REG_SIZE   5   data-memory address width
//  BANK_SIZE  32  number of words dumped (addresses 0..BANK_SIZE-1)
// PORTS
//  i_clock         in   1          system clock, rising edge
//  i_reset         in   1          asynchronous, active-high reset
//  i_pipe_mem_read in   1          MEM stage read request
//  i_pipe_mem_write in  1          MEM stage write request
//  i_pipe_addr     in   REG_SIZE   MEM stage word address
//  i_halt          in   1          pipeline halted (MEM stage is idle by definition)
//  i_dump_start    in   1          debug unit: start dump (level or pulse; sampled in IDLE only)
//  i_tx_ready      in   1          debug transmitter accepts o_tx_data
//  i_mem_rdata     in   DATA_SIZE  read data from mem_data, valid 1 cycle after address
//  o_mem_addr      out  REG_SIZE   address to mem_data
//  o_mem_read      out  1          read enable to mem_data
//  o_mem_write     out  1          write enable to mem_data
//  o_debug_flag    out  1          1 = debug owns the port
//  o_stall         out  1          freeze pipeline
//  o_tx_data       out  DATA_SIZE  dumped word
//  o_tx_valid      out  1          o_tx_data valid
//  o_busy          out  1          dump in progress
//  o_done          out  1          one-cycle pulse at dump end
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, o_tx_data=0, and every registered output=0.
//  Port mux: when o_debug_flag=0, o_mem_addr/read/write = i_pipe_addr/mem_read/mem_write (combinational).
//   When o_debug_flag=1: o_mem_addr=cnt, o_mem_write=0, o_mem_read=1 in READ only.
//  FSM:
//   IDLE    i_dump_start=1 -> DRAIN.
//   DRAIN   o_stall=1, o_busy=1. Go to READ when (!i_pipe_mem_read && !i_pipe_mem_write) || i_halt.
//           Otherwise hold in DRAIN.
//   READ    o_debug_flag=1, o_mem_read=1, address cnt. Next state CAPTURE.
//   CAPTURE register i_mem_rdata into o_tx_data; o_tx_valid<=1. Next state SEND.
//   SEND    hold o_tx_data and o_tx_valid stable until i_tx_ready=1.
//           On handshake: o_tx_valid<=0.
//           If cnt==BANK_SIZE-1 -> DONE; else cnt<=cnt+1 -> READ.
//   DONE    o_done=1 for exactly 1 cycle; cnt<=0; then -> IDLE.
//           Stall and grant drop in IDLE.
//  o_stall, o_busy and o_debug_flag are 1 in DRAIN, READ, CAPTURE, SEND and DONE.
//  Timing: minimum 3 cycles per word with i_tx_ready tied high.
//   Full dump = 1 (DRAIN) + 3*BANK_SIZE + 1 (DONE) cycles.
//  cnt is REG_SIZE wide. Compare against BANK_SIZE-1, so there is no wrap past the last word.
//  Boundary conditions:
//   i_dump_start while not IDLE: ignored.
//   i_dump_start held high through DONE: a new dump begins the cycle after IDLE is entered.
//   i_tx_ready high while o_tx_valid=0: ignored.
//   Pipeline requests during debug ownership are never forwarded; the pipeline is stalled.
//   Reset mid-dump: immediate return to IDLE. No o_done; o_tx_valid=0.
// CONFIGURATION
//  DMEM_DUMP_CHECKSUM_EN defined:
//   A running XOR of all dumped words (cleared in IDLE) is kept.
//   After the last word's handshake, the FSM enters CHKSUM: o_tx_data=XOR, o_tx_valid=1.
//   On handshake -> DONE. Dump length becomes BANK_SIZE+1 words.
//  DMEM_DUMP_CHECKSUM_EN undefined: no CHKSUM state and no XOR register; exactly BANK_SIZE words.
// TESTING
//  Idle passthrough: pipe read addr 5 -> o_mem_addr=5, o_mem_read=1, o_debug_flag=0, o_stall=0.
//  Full dump: mem[i]=i*4+1, ready=1, i_halt=1.
//   -> 32 words 1,5,..,125 in order; o_done 98 cycles after start.
//  Drain: dump_start while pipe write active for 3 cycles.
//   -> o_stall=1 immediately; first READ only after write deasserts; no write is lost or forwarded during the dump.
//  Backpressure: i_tx_ready low for 4 cycles on word 7.
//   -> o_tx_data=mem[7] held stable and o_tx_valid=1 throughout; no word skipped.
//  Reset at word 10: all outputs 0, state IDLE.
//   A new dump_start restarts from address 0.
//  CHECKSUM_EN, mem[i]=i: 33 words sent; last word = XOR(0..31) = 0; o_done follows.

Source files
------------

// File: rtl/dmem_dump_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_dump_arbiter
//
// Shares the single data-memory port between the pipeline MEM stage and the
// debug unit. A dump request stalls the pipeline, waits for the MEM stage to
// go quiet, then reads every data-memory word in address order and streams
// each one to the debug transmitter.
//
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN
//   When defined, a running XOR of all dumped words is kept and sent as one
//   extra word after the last memory word.
//
// Ports
//   i_clock          in   1          system clock, rising edge
//   i_reset          in   1          asynchronous, active-high reset
//   i_pipe_mem_read  in   1          MEM stage read request
//   i_pipe_mem_write in   1          MEM stage write request
//   i_pipe_addr      in   REG_SIZE   MEM stage word address
//   i_halt           in   1          pipeline halted (MEM stage idle)
//   i_dump_start     in   1          start a dump (sampled in IDLE only)
//   i_tx_ready       in   1          transmitter accepts o_tx_data
//   i_mem_rdata      in   DATA_SIZE  mem_data read data, 1 cycle after address
//   o_mem_addr       out  REG_SIZE   address to mem_data
//   o_mem_read       out  1          read enable to mem_data
//   o_mem_write      out  1          write enable to mem_data
//   o_debug_flag     out  1          debug owns the memory port
//   o_stall          out  1          freeze pipeline
//   o_tx_data        out  DATA_SIZE  dumped word
//   o_tx_valid       out  1          o_tx_data valid
//   o_busy           out  1          dump in progress
//   o_done           out  1          one-cycle pulse at dump end
//   o_state_dbg      out  3          current FSM state encoding
//
// Transmit link: a word transfers on a rising edge where o_tx_valid and
// i_tx_ready are both 1. Once o_tx_valid rises, o_tx_valid and o_tx_data hold
// stable until that transfer; i_tx_ready while o_tx_valid is 0 has no effect.
// ---------------------------------------------------------------------------
module dmem_dump_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int BANK_SIZE = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_pipe_mem_read,
    input  logic                 i_pipe_mem_write,
    input  logic [REG_SIZE-1:0]  i_pipe_addr,
    input  logic                 i_halt,
    input  logic                 i_dump_start,
    input  logic                 i_tx_ready,
    input  logic [DATA_SIZE-1:0] i_mem_rdata,
    output logic [REG_SIZE-1:0]  o_mem_addr,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_debug_flag,
    output logic                 o_stall,
    output logic [DATA_SIZE-1:0] o_tx_data,
    output logic                 o_tx_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4,
        S_DONE    = 3'd5
`ifdef DMEM_DUMP_CHECKSUM_EN
        ,S_CHKSUM = 3'd6
`endif
    } state_t;

    localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(BANK_SIZE - 1);

    state_t              state;
    state_t              state_next;
    logic [REG_SIZE-1:0] cnt;
    logic                owned;
    logic                dbg_read;
    logic                tx_fire;
    logic                last_word;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_SIZE-1:0] xor_acc;
`endif

    assign tx_fire     = o_tx_valid && i_tx_ready;
    assign last_word   = (cnt == LAST_ADDR);
    assign o_state_dbg = state;

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and ownership decode
    always_comb begin
        state_next = state;
        owned      = 1'b0;
        dbg_read   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_dump_start) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                owned = 1'b1;
                // A halted pipeline cannot have a request in flight.
                if ((!i_pipe_mem_read && !i_pipe_mem_write) || i_halt) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                owned      = 1'b1;
                dbg_read   = 1'b1;
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                owned      = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: begin
                owned = 1'b1;
                if (tx_fire) begin
                    if (last_word) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_next = S_CHKSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            S_CHKSUM: begin
                owned = 1'b1;
                if (tx_fire) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                owned      = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_debug_flag = owned;
    assign o_stall      = owned;
    assign o_busy       = owned;
    assign o_done       = (state == S_DONE);

    // Memory port mux: pipeline requests are never forwarded while owned.
    assign o_mem_addr  = owned ? cnt : i_pipe_addr;
    assign o_mem_read  = owned ? dbg_read : i_pipe_mem_read;
    assign o_mem_write = owned ? 1'b0 : i_pipe_mem_write;

    // Word counter and transmit register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt        <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            xor_acc    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                    xor_acc <= '0;
`endif
                end
                S_CAPTURE: begin
                    o_tx_data  <= i_mem_rdata;
                    o_tx_valid <= 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    xor_acc    <= xor_acc ^ i_mem_rdata;
`endif
                end
                S_SEND: begin
                    if (tx_fire) begin
                        if (last_word) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                            // Checksum word follows straight after the last data word.
                            o_tx_data  <= xor_acc;
                            o_tx_valid <= 1'b1;
`else
                            o_tx_valid <= 1'b0;
`endif
                        end else begin
                            o_tx_valid <= 1'b0;
                            cnt        <= cnt + REG_SIZE'(1);
                        end
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                S_CHKSUM: begin
                    if (tx_fire) begin
                        o_tx_valid <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
module tb_dmem_dump_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int BANK = 32;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int CHK_WORDS = 1;
`else
    localparam int CHK_WORDS = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_pipe_mem_read;
    logic          i_pipe_mem_write;
    logic [AW-1:0] i_pipe_addr;
    logic          i_halt;
    logic          i_dump_start;
    logic          i_tx_ready;
    logic [DW-1:0] i_mem_rdata;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_read;
    logic          o_mem_write;
    logic          o_debug_flag;
    logic          o_stall;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          o_busy;
    logic          o_done;
    logic [2:0]    o_state_dbg;

    always #5 i_clock = ~i_clock;

    dmem_dump_arbiter #(.DATA_SIZE(DW), .REG_SIZE(AW), .BANK_SIZE(BANK)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_pipe_mem_read  (i_pipe_mem_read),
        .i_pipe_mem_write (i_pipe_mem_write),
        .i_pipe_addr      (i_pipe_addr),
        .i_halt           (i_halt),
        .i_dump_start     (i_dump_start),
        .i_tx_ready       (i_tx_ready),
        .i_mem_rdata      (i_mem_rdata),
        .o_mem_addr       (o_mem_addr),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .o_debug_flag     (o_debug_flag),
        .o_stall          (o_stall),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_state_dbg      (o_state_dbg)
    );

    // ---------------- data memory model ----------------
    logic [DW-1:0] mem      [BANK];
    logic [DW-1:0] load_img [BANK];
    logic          do_load = 1'b0;
    logic [DW-1:0] pipe_wdata = '0;

    always @(posedge i_clock) begin
        if (do_load) mem <= load_img;
        else if (o_mem_write) mem[o_mem_addr] <= pipe_wdata;
        if (o_mem_read) i_mem_rdata <= mem[o_mem_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            sent;
    bit            prev_hold;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called at a falling edge with inputs already set for the coming
    // rising edge; observes what that edge will do, then advances one cycle.
    task automatic cycle();
        logic [DW-1:0] w;
        if (o_debug_flag) begin
            check("no_fwd_write", o_mem_write, 0);
            if (o_mem_read) check("dump_addr", o_mem_addr, sent);
        end
        if (prev_hold) begin
            check("hold_valid", o_tx_valid, 1);
            check("hold_data", o_tx_data, prev_data);
        end
        if (o_tx_valid && i_tx_ready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check($sformatf("word%0d", sent), o_tx_data, w);
            end
            sent++;
        end
        prev_hold = o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic load_mem(input int kind);
        for (int i = 0; i < BANK; i++) begin
            case (kind)
                0:       load_img[i] = i * 4 + 1;
                1:       load_img[i] = $urandom;
                default: load_img[i] = i;
            endcase
        end
        do_load = 1'b1;
        cycle();
        do_load = 1'b0;
    endtask

    task automatic do_reset_checks();
        i_pipe_mem_read  = 1'b0;
        i_pipe_mem_write = 1'b0;
        i_dump_start     = 1'b0;
        i_reset          = 1'b1;
        #1;
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_stall", o_stall, 0);
        check("rst_busy", o_busy, 0);
        check("rst_flag", o_debug_flag, 0);
        check("rst_done", o_done, 0);
        check("rst_mem_read", o_mem_read, 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        exp_q.delete();
        prev_hold = 1'b0;
        sent = 0;
        @(negedge i_clock);
    endtask

    // mode 0: ready high; 1: random ready + random pipe traffic;
    // 2: ready low for 4 cycles on word 7; 3: reset once word 10 is reached.
    task automatic run_dump(input int mode, input int drain_cycles, input bit hold_start, output int done_at);
        int ncyc;
        int hold;
        logic [DW-1:0] x;
        sent = 0;
        hold = 0;
        done_at = 0;
        prev_hold = 1'b0;
        i_dump_start = 1'b1;
        i_tx_ready = 1'b1;
        i_halt = (drain_cycles == 0);
        i_pipe_mem_read = 1'b0;
        i_pipe_mem_write = (drain_cycles > 0);
        i_pipe_addr = AW'($urandom_range(0, BANK - 1));
        pipe_wdata = $urandom;
        cycle();
        ncyc = 1;
        // Memory is frozen while debug owns the port: the expected stream is
        // the current contents in address order.
        exp_q.delete();
        x = '0;
        for (int i = 0; i < BANK; i++) begin
            exp_q.push_back(mem[i]);
            x ^= mem[i];
        end
        if (CHK_WORDS == 1) exp_q.push_back(x);
        check("stall_now", o_stall, 1);
        check("busy_now", o_busy, 1);
        if (!hold_start) i_dump_start = 1'b0;
        while (ncyc < 3000) begin
            if (o_done) begin
                done_at = ncyc;
                break;
            end
            if (mode == 3 && sent == 10) break;
            if (drain_cycles > 0) begin
                i_pipe_mem_write = (ncyc < drain_cycles);
                if (i_pipe_mem_write) check("drain_no_read", o_mem_read, 0);
            end
            case (mode)
                1: begin
                    i_tx_ready       = 1'($urandom_range(0, 1));
                    i_pipe_mem_read  = 1'($urandom_range(0, 1));
                    i_pipe_mem_write = 1'($urandom_range(0, 1));
                    i_pipe_addr      = AW'($urandom_range(0, BANK - 1));
                    if (!hold_start) i_dump_start = 1'($urandom_range(0, 1));
                end
                2: begin
                    if (o_tx_valid && sent == 7 && hold < 4) begin
                        i_tx_ready = 1'b0;
                        hold++;
                    end else begin
                        i_tx_ready = 1'b1;
                    end
                end
                default: i_tx_ready = 1'b1;
            endcase
            cycle();
            ncyc++;
        end
        i_pipe_mem_read = 1'b0;
        i_pipe_mem_write = 1'b0;
        if (mode == 3) begin
            check("reached_word10", sent, 10);
            do_reset_checks();
        end else begin
            check("done_seen", done_at != 0, 1);
            check("words_left", exp_q.size(), 0);
            check("words_sent", sent, BANK + CHK_WORDS);
            check("done_valid_low", o_tx_valid, 0);
            if (!hold_start) i_dump_start = 1'b0;
            cycle();
            check("done_pulse", o_done, 0);
            check("idle_busy", o_busy, 0);
            check("idle_stall", o_stall, 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int done_at;
        int wa;
        logic [DW-1:0] wd;
        i_reset = 1'b1;
        i_pipe_mem_read = 1'b0;
        i_pipe_mem_write = 1'b0;
        i_pipe_addr = '0;
        i_halt = 1'b0;
        i_dump_start = 1'b0;
        i_tx_ready = 1'b0;
        prev_hold = 1'b0;
        sent = 0;
        #3;
        check("init_tx_valid", o_tx_valid, 0);
        check("init_tx_data", o_tx_data, 0);
        check("init_stall", o_stall, 0);
        check("init_busy", o_busy, 0);
        check("init_flag", o_debug_flag, 0);
        check("init_done", o_done, 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Idle passthrough
        i_pipe_mem_read = 1'b1;
        i_pipe_addr = 5'd5;
        #1;
        check("pt_addr", o_mem_addr, 5);
        check("pt_read", o_mem_read, 1);
        check("pt_flag", o_debug_flag, 0);
        check("pt_stall", o_stall, 0);
        for (int i = 0; i < 8; i++) begin
            i_pipe_mem_read  = 1'($urandom_range(0, 1));
            i_pipe_mem_write = 1'($urandom_range(0, 1));
            i_pipe_addr      = AW'($urandom_range(0, BANK - 1));
            #1;
            check("pt_rand_addr", o_mem_addr, i_pipe_addr);
            check("pt_rand_read", o_mem_read, i_pipe_mem_read);
            check("pt_rand_write", o_mem_write, i_pipe_mem_write);
        end
        i_pipe_mem_read = 1'b0;
        i_pipe_mem_write = 1'b0;
        @(negedge i_clock);

        // Full dump, ready high, pipeline halted
        load_mem(0);
        run_dump(0, 0, 1'b0, done_at);
        check("full_latency", done_at, 1 + 3 * BANK + CHK_WORDS + 1);

        // Drain: pipeline write stays active for 3 cycles after the request
        load_mem(1);
        run_dump(0, 3, 1'b0, done_at);
        check("drain_latency", done_at, 1 + 2 + 3 * BANK + CHK_WORDS + 1);
        // The stalled write is reissued once the port is released.
        wa = int'(i_pipe_addr);
        wd = $urandom;
        pipe_wdata = wd;
        i_pipe_mem_write = 1'b1;
        #1;
        check("reissue_write", o_mem_write, 1);
        check("reissue_addr", o_mem_addr, wa);
        cycle();
        i_pipe_mem_write = 1'b0;
        check("reissue_landed", mem[wa], wd);

        // Backpressure on word 7
        load_mem(1);
        run_dump(2, 0, 1'b0, done_at);
        check("bp_latency", done_at, 1 + 3 * BANK + 4 + CHK_WORDS + 1);

        // Random ready and pipeline traffic, start request toggling mid-dump
        load_mem(1);
        run_dump(1, 0, 1'b0, done_at);

        // Start held high through DONE: re-arms the cycle after IDLE
        load_mem(1);
        run_dump(0, 0, 1'b1, done_at);
        cycle();
        check("rearm_busy", o_busy, 1);
        do_reset_checks();

        // Reset at word 10, then a fresh dump starting from address 0
        load_mem(1);
        run_dump(3, 0, 1'b0, done_at);
        run_dump(0, 0, 1'b0, done_at);
        check("post_rst_latency", done_at, 1 + 3 * BANK + CHK_WORDS + 1);

`ifdef DMEM_DUMP_CHECKSUM_EN
        // mem[i]=i: checksum word is XOR(0..31) = 0
        load_mem(2);
        run_dump(0, 0, 1'b0, done_at);
        check("chk_latency", done_at, 1 + 3 * BANK + 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
